// File: rtl/uart_report_pkg.sv
// Shared constants, ASCII helpers and FSM state encoding for the UART
// counter reporter.
package uart_report_pkg;

  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // "W=" + wr nibbles + " R=" + rd nibbles + CR LF
  function automatic int unsigned msg_len(input int unsigned cnt_w);
    return 7 + 2 * (cnt_w / 4);
  endfunction

  localparam int unsigned DEF_CNT_W = 24;
  localparam int unsigned MSG_LEN   = msg_len(DEF_CNT_W);

  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser with a valid/ready handshake; ready is also offered in
// the last stop-bit cycle so consecutive bytes go out back-to-back.
module uart_byte_tx
  import uart_report_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       stop_near_o,
  output logic       tx_o
);

  localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            tx_q, tx_d;
  logic            bit_end;

  assign bit_end     = (baud_q == BW'(BAUD_DIV - 1));
  assign ready_o     = (state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_end);
  assign stop_near_o = (state_q == ST_STOP) && (baud_q == BW'(BAUD_DIV - 2));
  assign tx_o        = tx_q;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    if (state_q != ST_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          state_d = ST_START;
          baud_d  = '0;
          sh_d    = data_i;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = sh_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
            sh_d  = {1'b0, sh_q[7:1]};
            tx_d  = sh_q[1];
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (valid_i) begin
            state_d = ST_START;
            sh_d    = data_i;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_cnt_report.sv
// Periodically snapshots the write/read byte counters and prints them as
// "W=hhhhhh R=hhhhhh\r\n" on an 8N1 UART line.
module uart_cnt_report
  import uart_report_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned BAUD          = 115200,
  parameter int unsigned REPORT_CYCLES = 50_000_000,
  parameter int unsigned CNT_W         = 24
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             report_en,
  input  logic [CNT_W-1:0] wr_cnt,
  input  logic [CNT_W-1:0] rd_cnt,
  output logic             uart_tx,
  output logic             busy
);

  localparam int unsigned BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned NIB      = CNT_W / 4;
  localparam int unsigned LEN      = msg_len(CNT_W);
  localparam int unsigned IDX_W    = $clog2(LEN);
  localparam int unsigned TW       = (REPORT_CYCLES > 1) ? $clog2(REPORT_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  logic [TW-1:0]    timer_q, timer_d;
  logic             tick;
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic             busy_q, busy_d;
  logic [7:0]       ch;
  logic             tx_valid, tx_ready, tx_stop_near;

  assign tick    = (timer_q == TW'(REPORT_CYCLES - 1));
  assign timer_d = tick ? '0 : timer_q + 1'b1;
  assign busy    = busy_q;

  always_comb begin
    int unsigned i;
    logic [3:0]  nib;
    i   = 32'(idx_q);
    nib = '0;
    ch  = ASCII_LF;
    if (i == 0) begin
      ch = ASCII_W;
    end else if (i == 1) begin
      ch = ASCII_EQ;
    end else if (i < NIB + 2) begin
      nib = 4'(wr_q >> (4 * (NIB + 1 - i)));
      ch  = nib2ascii(nib);
    end else if (i == NIB + 2) begin
      ch = ASCII_SP;
    end else if (i == NIB + 3) begin
      ch = ASCII_R;
    end else if (i == NIB + 4) begin
      ch = ASCII_EQ;
    end else if (i < 2 * NIB + 5) begin
      nib = 4'(rd_q >> (4 * (2 * NIB + 4 - i)));
      ch  = nib2ascii(nib);
    end else if (i == 2 * NIB + 5) begin
      ch = ASCII_CR;
    end
  end

  // LOAD keeps the next byte on offer so the serialiser takes it in its last
  // stop cycle; ST_STOP here means "final byte in flight" and releases busy
  // one cycle ahead of the line going idle, so busy spans exactly one
  // message time starting at the snapshot edge.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    busy_d   = busy_q;
    tx_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick && report_en) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          wr_d    = wr_cnt;
          rd_d    = rd_cnt;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tx_stop_near) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          idx_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      state_q <= ST_IDLE;
      idx_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
    end
  end

  uart_byte_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_byte_tx (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .data_i     (ch),
    .valid_i    (tx_valid),
    .ready_o    (tx_ready),
    .stop_near_o(tx_stop_near),
    .tx_o       (uart_tx)
  );

endmodule

// File: tb/tb_uart_cnt_report.sv
// Directed bench for uart_cnt_report: two instances (3000- and 1000-cycle
// report periods) at BAUD_DIV=10, lines decoded at fixed bit centres.
module tb_uart_cnt_report;

  localparam int unsigned CF   = 1_000_000;
  localparam int unsigned BD   = 100_000;
  localparam int          RC_A = 3000;
  localparam int          RC_B = 1000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_a  = 1'b0;
  logic        en_b  = 1'b0;
  logic [23:0] wr_cnt = '0;
  logic [23:0] rd_cnt = '0;
  logic        tx_a, busy_a, tx_b, busy_b;

  int   ecnt;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   brise_a = 0, blen_a = 0, brise_b = 0, blen_b = 0;
  logic bprev_a = 1'b0, bprev_b = 1'b0;

  always #5 clk = ~clk;

  uart_cnt_report #(
    .CLK_FREQ(CF), .BAUD(BD), .REPORT_CYCLES(RC_A), .CNT_W(24)
  ) u_dut_a (
    .sys_clk(clk), .rst_n(rst_n), .report_en(en_a),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .uart_tx(tx_a), .busy(busy_a)
  );

  uart_cnt_report #(
    .CLK_FREQ(CF), .BAUD(BD), .REPORT_CYCLES(RC_B), .CNT_W(24)
  ) u_dut_b (
    .sys_clk(clk), .rst_n(rst_n), .report_en(en_b),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .uart_tx(tx_b), .busy(busy_b)
  );

  // Edges since reset release: during the cycle after edge n, timer == n mod RC.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  always @(negedge clk) begin
    if (busy_a && !bprev_a) brise_a <= ecnt;
    if (!busy_a && bprev_a) blen_a  <= ecnt - brise_a;
    if (busy_b && !bprev_b) brise_b <= ecnt;
    if (!busy_b && bprev_b) blen_b  <= ecnt - brise_b;
    bprev_a <= busy_a;
    bprev_b <= busy_b;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at ecnt=%0d", ecnt);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [151:0] obs, input logic [151:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic txv(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  function automatic logic busyv(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  function automatic int next_tick(input int n, input int rc);
    return n + (rc - 1 - (n % rc));
  endfunction

  task automatic wait_until(input int t);
    while (ecnt < t) @(negedge clk);
  endtask

  // Both instances must stay idle-high and not busy up to edge count t_end.
  task automatic quiet(input string tag, input int t_end);
    int bad = 0;
    while (ecnt < t_end) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || tx_b !== 1'b1 || busy_b !== 1'b0) bad++;
    end
    chk(tag, 152'(bad), 152'(0));
  endtask

  // Busy must rise on the edge after the tick and the start bit one edge later.
  task automatic check_start(input string tag, input bit sel, input int f);
    wait_until(f - 1);
    chk({tag, "_pre"}, 152'({txv(sel), busyv(sel)}), 152'(2'b11));
    wait_until(f);
    chk({tag, "_fall"}, 152'(txv(sel)), 152'(1'b0));
  endtask

  task automatic line(input string tag, input bit sel, input int f, input logic [151:0] exp);
    logic [151:0] got;
    logic [7:0]   ch;
    logic         b;
    int           ferr;
    got  = '0;
    ch   = '0;
    ferr = 0;
    for (int k = 0; k < 19; k++) begin
      for (int j = 0; j < 10; j++) begin
        wait_until(f + 100 * k + 10 * j + 5);
        b = txv(sel);
        if (j == 0) begin
          if (b !== 1'b0) ferr++;
        end else if (j == 9) begin
          if (b !== 1'b1) ferr++;
        end else begin
          ch[j-1] = b;
        end
      end
      got = {got[143:0], ch};
    end
    chk({tag, "_text"}, got, exp);
    chk({tag, "_frame"}, 152'(ferr), 152'(0));
    wait_until(f + 1905);
    chk({tag, "_busylen"}, 152'(sel ? blen_b : blen_a), 152'(1900));
    chk({tag, "_idle"}, 152'({txv(sel), busyv(sel)}), 152'(2'b10));
  endtask

  initial begin
    int c;
    int f;
    wr_cnt = 24'h12AB3C;
    rd_cnt = 24'h00FF01;
    repeat (20) @(negedge clk);
    chk("rst_hold", 152'({tx_a, busy_a, tx_b, busy_b}), 152'(4'b1010));
    rst_n = 1'b1;
    quiet("rst_quiet", 10000);

    // Basic line, with wr_cnt changed 5 cycles after the tick.
    en_a = 1'b1;
    c = next_tick(ecnt, RC_A);
    f = c + 2;
    check_start("l1", 1'b0, f);
    wait_until(c + 5);
    wr_cnt = 24'hFFFFFF;
    line("l1", 1'b0, f, "W=12AB3C R=00FF01\r\n");

    // Next line picks up the new value; enable drops mid-line.
    c = c + RC_A;
    f = c + 2;
    check_start("l2", 1'b0, f);
    fork
      line("l2", 1'b0, f, "W=FFFFFF R=00FF01\r\n");
      begin
        wait_until(f + 500);
        en_a = 1'b0;
      end
    join
    quiet("gate_quiet", c + 2 * RC_A + 5);

    wr_cnt = 24'h000000;
    rd_cnt = 24'hABCDEF;
    en_a = 1'b1;
    c = next_tick(ecnt, RC_A);
    f = c + 2;
    check_start("l3", 1'b0, f);
    line("l3", 1'b0, f, "W=000000 R=ABCDEF\r\n");
    en_a = 1'b0;

    // 1000-cycle period: the tick during busy is dropped, the next one is taken.
    wr_cnt = 24'h000001;
    rd_cnt = 24'hFFFFFF;
    en_b = 1'b1;
    c = next_tick(ecnt, RC_B);
    f = c + 2;
    check_start("d1", 1'b1, f);
    fork
      line("d1", 1'b1, f, "W=000001 R=FFFFFF\r\n");
      begin
        wait_until(f + 100);
        rd_cnt = 24'h0F0F0F;
      end
    join
    quiet("drop_quiet", c + 2 * RC_B);
    check_start("d2", 1'b1, c + 2 * RC_B + 2);
    line("d2", 1'b1, c + 2 * RC_B + 2, "W=000001 R=0F0F0F\r\n");
    en_b = 1'b0;

    // Asynchronous reset during data bit 3 of the fifth character.
    en_a = 1'b1;
    c = next_tick(ecnt, RC_A);
    f = c + 2;
    check_start("r0", 1'b0, f);
    wait_until(f + 444);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 152'({tx_a, busy_a}), 152'(2'b10));
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    quiet("rst_restart", RC_A - 1);
    check_start("r1", 1'b0, RC_A + 1);
    line("r1", 1'b0, RC_A + 1, "W=000001 R=0F0F0F\r\n");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
